// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: ALU one-hot op codes, request op
// encoding and the ALU driver's state encoding.
package calc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0001;
  localparam logic [3:0] ALU_STOP = 4'b0000;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } req_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic [3:0] op_onehot(input req_op_t op);
    logic [3:0] code;
    code = ALU_STOP;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      default: code = ALU_STOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/calc_alu_driver.sv
// Request-side sequencer for the calculator ALU: accepts one request, pulses the
// one-hot op for a single cycle, follows the busy protocol and returns a flagged result.
module calc_alu_driver
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_sign,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [3:0] alu_op,
  output logic       alu_sign,
  output logic [3:0] alu_data1,
  output logic [3:0] alu_data2,
  input  logic       alu_busy,
  input  logic [7:0] alu_o,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_ovf,
  output logic       rsp_div0,
  output logic       rsp_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state;
  req_op_t       op_q;
  logic          sign_q;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [CW-1:0] cnt;
  logic [7:0]    result_q;
  logic          ovf_q;
  logic          div0_q;
  logic          err_q;

  logic       is_multi;
  logic [3:0] b_eff;
  logic       add_ovf;
  logic       timed_out;
  logic       first_run;

  // The ALU may still be draining after a reset, so new work waits for busy low.
  assign req_ready = (state == ST_IDLE) && !alu_busy;
  assign alu_op    = (state == ST_ISSUE) ? op_onehot(op_q) : ALU_STOP;
  assign alu_sign  = sign_q;
  assign alu_data1 = a_q;
  assign alu_data2 = b_q;

  assign rsp_valid  = (state == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_div0   = div0_q;
  assign rsp_err    = err_q;

  assign is_multi  = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign b_eff     = (op_q == OP_SUB) ? ~b_q : b_q;
  assign add_ovf   = sign_q && (a_q[3] == b_eff[3]) && (alu_o[3] != a_q[3]);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign first_run = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      sign_q   <= 1'b0;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      cnt      <= '0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q   <= req_op_t'(req_op);
            sign_q <= req_sign;
            a_q    <= req_a;
            b_q    <= req_b;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= is_multi ? ST_RUN : ST_SETTLE;
        end
        ST_SETTLE: begin
          // Upper ALU bits are left over from earlier ops for add/sub.
          result_q <= {3'b000, alu_o[4:0]};
          ovf_q    <= add_ovf;
          state    <= ST_RESP;
        end
        ST_RUN: begin
          if (!alu_busy) begin
            if (first_run) begin
              err_q    <= 1'b1;
              result_q <= 8'h00;
            end else if ((op_q == OP_DIV) && (b_q == 4'h0)) begin
              div0_q   <= 1'b1;
              result_q <= 8'h00;
            end else begin
              result_q <= alu_o;
            end
            state <= ST_RESP;
          end else if (timed_out) begin
            err_q    <= 1'b1;
            result_q <= 8'h00;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            ovf_q  <= 1'b0;
            div0_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_alu_driver.sv
// Bench for calc_alu_driver: behavioural ALU with fault modes, a table of
// request vectors checked through a scoreboard queue, plus reset/fault sequences.
module tb_calc_alu_driver;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic       req_sign = 1'b0;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
  logic [3:0] alu_op;
  logic       alu_sign;
  logic [3:0] alu_data1;
  logic [3:0] alu_data2;
  logic       alu_busy = 1'b0;
  logic [7:0] alu_o = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_ovf;
  logic       rsp_div0;
  logic       rsp_err;

  calc_alu_driver #(.TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sign(req_sign), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_sign(alu_sign), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_busy(alu_busy), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ovf(rsp_ovf), .rsp_div0(rsp_div0), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural ALU ----------------
  localparam int M_NORMAL = 0;
  localparam int M_NOBUSY = 1;
  localparam int M_STUCK  = 2;
  int         alu_mode = M_NORMAL;
  int         alu_cnt = 0;
  logic [7:0] alu_pend = 8'h00;

  function automatic logic [7:0] model_mul(input logic [3:0] a, input logic [3:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 8'(x * y);
  endfunction

  function automatic logic [7:0] model_div(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y, q, r;
    if (b == 4'h0) return 8'hFF;
    if (s) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    q = x / y;
    r = x % y;
    return {4'(q), 4'(r)};
  endfunction

  always @(posedge clk) begin
    if (alu_mode == M_STUCK) begin
      alu_busy <= 1'b1;
      alu_cnt  <= 0;
    end else if (alu_op == ALU_ADD) begin
      alu_o <= {3'($urandom), 5'({1'b0, alu_data1} + {1'b0, alu_data2})};
    end else if (alu_op == ALU_SUB) begin
      alu_o <= {3'($urandom), 5'({1'b0, alu_data1} - {1'b0, alu_data2})};
    end else if (alu_op == ALU_MUL || alu_op == ALU_DIV) begin
      if (alu_mode == M_NORMAL) begin
        alu_busy <= 1'b1;
        alu_cnt  <= (alu_op == ALU_DIV && alu_data2 == 4'h0) ? 1 : 9;
        alu_pend <= (alu_op == ALU_MUL) ? model_mul(alu_data1, alu_data2)
                                        : model_div(alu_data1, alu_data2, alu_sign);
      end
    end else if (alu_busy && alu_cnt == 0) begin
      alu_busy <= 1'b0;
      alu_o    <= alu_pend;
    end else if (alu_busy) begin
      alu_cnt <= alu_cnt - 1;
    end
  end

  // Count cycles on which the driver presents a non-STOP op.
  int         op_cycles = 0;
  logic [3:0] last_op = 4'h0;
  always @(negedge clk) begin
    if (alu_op != 4'h0) begin
      op_cycles <= op_cycles + 1;
      last_op   <= alu_op;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_onehot(input logic [1:0] op);
    case (op)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  typedef struct {
    logic [1:0] op;
    logic       sign;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] result;
    logic       ovf;
    logic       div0;
    logic       err;
    int         lat;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[12];

  task automatic do_txn(input vec_t v, input int bp_cycles);
    int   n;
    vec_t e;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_sign  = v.sign;
    req_a     = v.a;
    req_b     = v.b;
    sb.push_back(v);
    @(posedge clk);
    op_cycles = 0;
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 100);
    e = sb.pop_front();
    check("latency", n, e.lat);
    check("result", {24'd0, rsp_result}, {24'd0, e.result});
    check("ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
    check("div0", {31'd0, rsp_div0}, {31'd0, e.div0});
    check("err", {31'd0, rsp_err}, {31'd0, e.err});
    check("op_pulse_len", op_cycles, 1);
    check("op_code", {28'd0, last_op}, {28'd0, exp_onehot(e.op)});
    for (int k = 0; k < bp_cycles; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", {24'd0, rsp_result}, {24'd0, e.result});
      check("bp_flags", {29'd0, rsp_ovf, rsp_div0, rsp_err}, {29'd0, e.ovf, e.div0, e.err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_flags", {29'd0, rsp_ovf, rsp_div0, rsp_err}, 32'd0);
    check("post_result_hold", {24'd0, rsp_result}, {24'd0, e.result});
    $display("txn op=%0d sign=%0d a=%h b=%h -> result=%h ovf=%0d div0=%0d err=%0d lat=%0d",
             e.op, e.sign, e.a, e.b, e.result, e.ovf, e.div0, e.err, n);
  endtask

  initial begin
    vec_t f;
    int   n;
    //          op    sg    a     b     result  ovf   div0  err  lat
    vecs[0]  = '{2'd0, 1'b0, 4'h7, 4'h5, 8'h0C, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{2'd1, 1'b1, 4'h7, 4'hF, 8'h18, 1'b1, 1'b0, 1'b0, 2};
    vecs[2]  = '{2'd2, 1'b0, 4'hD, 4'h5, 8'hF1, 1'b0, 1'b0, 1'b0, 12};
    vecs[3]  = '{2'd3, 1'b0, 4'hD, 4'h4, 8'h31, 1'b0, 1'b0, 1'b0, 12};
    vecs[4]  = '{2'd3, 1'b0, 4'hD, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 4};
    vecs[5]  = '{2'd0, 1'b1, 4'h7, 4'h1, 8'h08, 1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{2'd0, 1'b0, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b0, 1'b0, 2};
    vecs[7]  = '{2'd1, 1'b0, 4'h3, 4'h5, 8'h1E, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{2'd3, 1'b1, 4'h9, 4'h2, 8'hDF, 1'b0, 1'b0, 1'b0, 12};
    vecs[9]  = '{2'd2, 1'b1, 4'h7, 4'h7, 8'h31, 1'b0, 1'b0, 1'b0, 12};
    vecs[10] = '{2'd1, 1'b1, 4'h8, 4'h1, 8'h07, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{2'd0, 1'b1, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b0, 1'b0, 2};

    // Reset state
    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_ctl", {23'd0, alu_sign, alu_data1, alu_data2}, 32'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_result, rsp_ovf, rsp_div0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i], (i == 1 || i == 4) ? 5 : 0);
    end

    // ALU never raises busy: error after the first RUN cycle
    alu_mode = M_NOBUSY;
    f = '{2'd2, 1'b0, 4'h3, 4'h3, 8'h00, 1'b0, 1'b0, 1'b1, 2};
    do_txn(f, 0);

    // ALU stuck busy: timeout after 31 RUN cycles
    alu_mode = M_STUCK;
    f = '{2'd3, 1'b0, 4'h9, 4'h2, 8'h00, 1'b0, 1'b0, 1'b1, 32};
    do_txn(f, 0);
    check("stuck_req_ready_low", {31'd0, req_ready}, 32'd0);
    alu_mode = M_NORMAL;
    @(posedge clk); #1;
    check("unstuck_req_ready", {31'd0, req_ready}, 32'd1);

    // Reset during RUN of a multiply
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_sign  = 1'b0;
    req_a     = 4'hD;
    req_b     = 4'h5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("mid_rst_alu_ctl", {23'd0, alu_sign, alu_data1, alu_data2}, 32'd0);
    check("mid_rst_rsp", {22'd0, rsp_valid, rsp_result, rsp_ovf, rsp_div0, rsp_err}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (alu_busy && n < 50) begin
      check("drain_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, alu_busy}, 32'd0);
    check("drain_req_ready_high", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    do_txn(vecs[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
